// File: rtl/ram_dump_pkg.sv
// Shared types and constants for the RAM dump engine and its Intel-HEX record stream.
package ram_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EMIT,
        ST_NEXT,
        ST_EOF,
        ST_DONE
    } dump_state_t;

    localparam logic [7:0] REC_DATA     = 8'h00;
    localparam logic [7:0] REC_EOF      = 8'h01;
    localparam logic [7:0] REC_DATA_LEN = 8'h04;

    typedef struct packed {
        logic [7:0]  rec_type;
        logic [7:0]  len;
        logic [15:0] addr;
        logic [31:0] data;
        logic [7:0]  cksum;
    } hex_rec_t;

    function automatic hex_rec_t eof_record();
        return '{rec_type: REC_EOF, len: 8'h00, addr: 16'h0000, data: 32'h0, cksum: 8'hFF};
    endfunction

endpackage

// File: rtl/ram_dump_engine_if.sv
// RAM-side generic bus plus the outgoing record stream of the dump engine.
interface ram_dump_engine_if;
    logic [31:0] bus_addr;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byte_en;
    logic [31:0] bus_rdata;
    logic        bus_busy;
    logic        rec_valid;
    logic        rec_ready;
    logic [7:0]  rec_type;
    logic [7:0]  rec_len;
    logic [15:0] rec_addr;
    logic [31:0] rec_data;
    logic [7:0]  rec_cksum;

    modport master (
        output bus_addr, bus_ren, bus_wen, bus_wdata, bus_byte_en,
        input  bus_rdata, bus_busy,
        output rec_valid, rec_type, rec_len, rec_addr, rec_data, rec_cksum,
        input  rec_ready
    );

    modport slave (
        input  bus_addr, bus_ren, bus_wen, bus_wdata, bus_byte_en,
        output bus_rdata, bus_busy,
        input  rec_valid, rec_type, rec_len, rec_addr, rec_data, rec_cksum,
        output rec_ready
    );
endinterface

// File: rtl/endian_swapper.sv
// Optional byte reversal of a 32-bit word; a straight wire when SWAP is 0.
module endian_swapper #(
    parameter bit SWAP = 1'b0
) (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    assign dout = SWAP ? {din[7:0], din[15:8], din[23:16], din[31:24]} : din;
endmodule

// File: rtl/hex_cksum.sv
// Intel-HEX checksum: two's complement of the byte sum of len, address, type and data.
module hex_cksum (
    input  logic [7:0]  len,
    input  logic [15:0] addr,
    input  logic [7:0]  rec_type,
    input  logic [31:0] data,
    output logic [7:0]  cksum
);
    logic [7:0] sum;

    always_comb begin
        sum = len + addr[15:8] + addr[7:0] + rec_type
            + data[31:24] + data[23:16] + data[15:8] + data[7:0];
        cksum = ~sum + 8'd1;
    end
endmodule

// File: rtl/ram_dump_engine.sv
// Walks a RAM window over the generic bus and emits one Intel-HEX record per
// non-zero word, followed by a single EOF record.
//
// state | meaning
// IDLE  | core owns the RAM bus, waiting for start
// REQ   | turnaround / launch read at ptr
// WAIT  | read in flight, held until bus_busy falls
// EMIT  | data record presented, held until rec_ready
// NEXT  | decide between next word and end of window
// EOF   | EOF record presented, held until rec_ready
// DONE  | one-cycle done pulse, bus returns to core
module ram_dump_engine
    import ram_dump_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] END_ADDR   = 32'h0000_2000,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              busy_dump,
    output logic              done,
    output logic              ram_control,
    ram_dump_engine_if.master bus
);

    if (BASE_ADDR >= END_ADDR || BASE_ADDR[1:0] != 2'b00 || END_ADDR[1:0] != 2'b00) begin : g_bad_window
        $error("ram_dump_engine: window must be word aligned and non-empty");
    end

    dump_state_t state, state_nxt;
    logic [31:0] ptr;
    logic [31:0] word_sw;
    logic [7:0]  cksum_w;
    hex_rec_t    rec_q;
    logic        rec_valid_q;

    endian_swapper #(.SWAP(BIG_ENDIAN)) u_swap (
        .din  (bus.bus_rdata),
        .dout (word_sw)
    );

    hex_cksum u_cksum (
        .len      (REC_DATA_LEN),
        .addr     (ptr[17:2]),
        .rec_type (REC_DATA),
        .data     (word_sw),
        .cksum    (cksum_w)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ:  state_nxt = ST_WAIT;
            ST_WAIT: if (!bus.bus_busy) state_nxt = (word_sw == 32'h0) ? ST_NEXT : ST_EMIT;
            ST_EMIT: if (bus.rec_ready) state_nxt = ST_NEXT;
            ST_NEXT: state_nxt = (ptr == END_ADDR) ? ST_EOF : ST_REQ;
            ST_EOF:  if (bus.rec_ready) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_control = (state == ST_IDLE);
        busy_dump   = (state != ST_IDLE) && (state != ST_DONE);
        done        = (state == ST_DONE);
    end

    // Bus request and record fields are registered so they hold across busy/ready stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr          <= 32'h0;
            bus.bus_addr <= 32'h0;
            bus.bus_ren  <= 1'b0;
            rec_q        <= '0;
            rec_valid_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) ptr <= BASE_ADDR;
                ST_REQ: begin
                    bus.bus_addr <= ptr;
                    bus.bus_ren  <= 1'b1;
                end
                ST_WAIT: if (!bus.bus_busy) begin
                    bus.bus_ren <= 1'b0;
                    if (word_sw == 32'h0) begin
                        ptr <= ptr + 32'd4;
                    end else begin
                        rec_q <= '{rec_type: REC_DATA, len: REC_DATA_LEN, addr: ptr[17:2],
                                   data: word_sw, cksum: cksum_w};
                        rec_valid_q <= 1'b1;
                    end
                end
                ST_EMIT: if (bus.rec_ready) begin
                    rec_valid_q <= 1'b0;
                    ptr         <= ptr + 32'd4;
                end
                ST_NEXT: if (ptr == END_ADDR) begin
                    rec_q       <= eof_record();
                    rec_valid_q <= 1'b1;
                end
                ST_EOF: if (bus.rec_ready) begin
                    rec_valid_q <= 1'b0;
                    rec_q       <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_wen     = 1'b0;
    assign bus.bus_wdata   = 32'h0;
    assign bus.bus_byte_en = 4'hF;
    assign bus.rec_valid   = rec_valid_q;
    assign bus.rec_type    = rec_q.rec_type;
    assign bus.rec_len     = rec_q.len;
    assign bus.rec_addr    = rec_q.addr;
    assign bus.rec_data    = rec_q.data;
    assign bus.rec_cksum   = rec_q.cksum;

endmodule
